// File: rtl/timer_multi.sv
// Multi-channel pulse timer: per channel one-shot, retriggerable one-shot or
// periodic square wave, with a programmable length and a per-channel prescaler.
module timer_multi #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int PW  = 8
) (
  input  logic              CLK,
  input  logic              R,
  input  logic [NCH-1:0]    TRG,
  input  logic [2*NCH-1:0]  MODE,
  input  logic [W*NCH-1:0]  LEN,
  input  logic [PW*NCH-1:0] PRESC,
  input  logic [NCH-1:0]    STOP,
  output logic [NCH-1:0]    OUT,
  output logic [NCH-1:0]    DONE
);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {
    M_ONESHOT  = 2'b00,
    M_RETRIG   = 2'b01,
    M_PERIODIC = 2'b10,
    M_OFF      = 2'b11
  } mode_e;

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [W-1:0]    cnt_q   [NCH];
  logic [W-1:0]    cnt_d   [NCH];
  logic [PW-1:0]   psc_q   [NCH];
  logic [PW-1:0]   psc_d   [NCH];
  logic [NCH-1:0]  trg_q;
  logic [NCH-1:0]  trig;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  out_d;
  logic [NCH-1:0]  done_d;

  assign trig = TRG & ~trg_q;

  for (genvar g = 0; g < NCH; g++) begin : g_tick
    assign tick[g] = (psc_q[g] == PRESC[PW*g +: PW]);
  end

  // Priority per channel: abort (STOP / disabled) > start or retrigger > expiry > count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    out_d  = OUT;
    done_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      psc_d[i]   = psc_q[i];
      if (mode_e'(MODE[2*i +: 2]) == M_OFF || STOP[i]) begin
        state_d[i] = IDLE;
        out_d[i]   = 1'b0;
      end else if (state_q[i] == IDLE) begin
        if (trig[i] && LEN[W*i +: W] != '0) begin
          state_d[i] = RUN;
          out_d[i]   = 1'b1;
          cnt_d[i]   = LEN[W*i +: W];
          psc_d[i]   = '0;
        end
      end else if (trig[i] && LEN[W*i +: W] != '0 &&
                   mode_e'(MODE[2*i +: 2]) != M_ONESHOT) begin
        out_d[i] = 1'b1;
        cnt_d[i] = LEN[W*i +: W];
        psc_d[i] = '0;
      end else if (tick[i] && cnt_q[i] <= W'(1)) begin
        // cnt of 0 can only come from a periodic reload with LEN=0; expire rather than wrap.
        done_d[i] = 1'b1;
        if (mode_e'(MODE[2*i +: 2]) == M_PERIODIC) begin
          out_d[i] = ~OUT[i];
          cnt_d[i] = LEN[W*i +: W];
          psc_d[i] = '0;
        end else begin
          state_d[i] = IDLE;
          out_d[i]   = 1'b0;
        end
      end else if (tick[i]) begin
        cnt_d[i] = cnt_q[i] - W'(1);
        psc_d[i] = '0;
      end else begin
        psc_d[i] = psc_q[i] + PW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all channels update together.
  always_ff @(posedge CLK) begin
    if (R) begin
      trg_q <= '0;
      OUT   <= '0;
      DONE  <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        psc_q[i]   <= '0;
      end
    end else begin
      trg_q <= TRG;
      OUT   <= out_d;
      DONE  <= done_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        psc_q[i]   <= psc_d[i];
      end
    end
  end

endmodule
